// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, stall and flush bubbles.
// Define IF_ID_SKID_EN to add a skid entry and register in_ready.
module if_id_pipe_reg #(
    parameter int unsigned         PC_W      = 64,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

`ifdef IF_ID_SKID_EN
    typedef enum logic [1:0] {StEmpty, StMain, StFull} state_e;
`else
    typedef enum logic [0:0] {StEmpty, StMain} state_e;
`endif

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [PC_W-1:0]     main_pc_q, main_pc_d;
    logic [INSTR_W-1:0]  main_instr_q, main_instr_d;
    logic                in_xfer, out_xfer;

`ifdef IF_ID_SKID_EN
    logic                in_ready_q, in_ready_d;
    logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
`ifdef IF_ID_SKID_EN
        in_ready_d   = in_ready_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
`endif
        if (flush) begin
            // Flush wins over any simultaneous accept; the register returns to a bubble.
            state_d      = StEmpty;
            out_valid_d  = 1'b0;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
`ifdef IF_ID_SKID_EN
            in_ready_d   = 1'b1;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
`endif
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d      = StMain;
                        out_valid_d  = 1'b1;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                StMain: begin
                    if (in_xfer && out_xfer) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (out_xfer) begin
                        // Clear contents so an invalid entry always reads as a NOP at PC 0.
                        state_d      = StEmpty;
                        out_valid_d  = 1'b0;
                        main_pc_d    = '0;
                        main_instr_d = NOP_INSTR;
`ifdef IF_ID_SKID_EN
                    end else if (in_xfer) begin
                        state_d      = StFull;
                        in_ready_d   = 1'b0;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
`endif
                    end
                end
`ifdef IF_ID_SKID_EN
                StFull: begin
                    if (out_xfer) begin
                        state_d      = StMain;
                        in_ready_d   = 1'b1;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        skid_pc_d    = '0;
                        skid_instr_d = NOP_INSTR;
                    end
                end
                default: begin
                    state_d      = StEmpty;
                    out_valid_d  = 1'b0;
                    in_ready_d   = 1'b1;
                    main_pc_d    = '0;
                    main_instr_d = NOP_INSTR;
                    skid_pc_d    = '0;
                    skid_instr_d = NOP_INSTR;
                end
`endif
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StEmpty;
            out_valid_q  <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
`ifdef IF_ID_SKID_EN
            in_ready_q   <= 1'b1;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
`ifdef IF_ID_SKID_EN
            in_ready_q   <= in_ready_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed test-plan checks plus random
// traffic compared each cycle against a queue-based model of the register.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0] in_pc, out_pc;
    logic [31:0] in_instr, out_instr;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          done    = 1'b0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t q[$];

    if_id_pipe_reg #(
        .PC_W      (64),
        .INSTR_W   (32),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Capacity 1 needs a free slot or a simultaneous drain; capacity 2 only looks at occupancy.
    function automatic logic model_ready();
`ifdef IF_ID_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    initial begin
        logic rdy, ix, ox;
        forever begin
            @(negedge clk);
            if (!done) begin
                if (reset) q.delete();
                check("out_valid", 64'(out_valid), 64'(q.size() != 0));
                check("out_pc", out_pc, (q.size() != 0) ? q[0].pc : 64'h0);
                check("out_instr", 64'(out_instr), 64'((q.size() != 0) ? q[0].instr : NOP));
                check("in_ready", 64'(in_ready), 64'(model_ready()));
                if (!reset) begin
                    rdy = model_ready();
                    ix  = in_valid && rdy;
                    ox  = (q.size() != 0) && out_ready;
                    if (flush) q.delete();
                    else begin
                        if (ox) void'(q.pop_front());
                        if (ix) q.push_back(entry_t'{pc: in_pc, instr: in_instr});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_pc = 64'h0; in_instr = 32'h0050_0093;
        out_ready = 1'b1; flush = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_instr", 64'(out_instr), 64'h13);
        check("rst_pc", out_pc, 64'h0);
        reset = 1'b0;
        tick();
        check("rel_valid", 64'(out_valid), 64'h1);
        check("rel_instr", 64'(out_instr), 64'h0050_0093);

        // Streaming
        in_pc = 64'h4; in_instr = 32'h00A0_0113;
        tick();
        check("stream_pc4", out_pc, 64'h4);
        check("stream_instr4", 64'(out_instr), 64'h00A0_0113);
        in_pc = 64'h8; in_instr = 32'h0020_81B3;
        tick();
        check("stream_pc8", out_pc, 64'h8);
        check("stream_valid", 64'(out_valid), 64'h1);

        // Stall with PC 0x4 held
        in_pc = 64'h4; in_instr = 32'h00A0_0113;
        tick();
        check("stall_pre_pc", out_pc, 64'h4);
        out_ready = 1'b0; in_pc = 64'h8; in_instr = 32'h0020_81B3;
`ifdef IF_ID_SKID_EN
        tick();
        in_valid = 1'b0;
        check("skid_full_ready", 64'(in_ready), 64'h0);
        check("skid_full_pc", out_pc, 64'h4);
        tick();
        check("skid_hold_pc", out_pc, 64'h4);
        out_ready = 1'b1;
        tick();
        check("skid_drain_pc8", out_pc, 64'h8);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", 64'(in_ready), 64'h0);
            check("stall_pc", out_pc, 64'h4);
        end
        out_ready = 1'b1;
        tick();
        check("stall_release_pc8", out_pc, 64'h8);
        in_valid = 1'b0;
`endif
        tick();
        check("drained_valid", 64'(out_valid), 64'h0);

        // Flush while stalled (FULL in skid builds) with PC 0x10 presented
        in_valid = 1'b1; in_pc = 64'h4; in_instr = 32'h00A0_0113;
        tick();
        out_ready = 1'b0; in_pc = 64'h8; in_instr = 32'h0020_81B3;
        tick();
        in_pc = 64'h10; in_instr = 32'h0000_0033; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_instr", 64'(out_instr), 64'h13);
        check("flush_pc", out_pc, 64'h0);
        tick();
        check("flush_no_ghost", 64'(out_valid), 64'h0);

        // Flush with an accept that would otherwise succeed
        in_valid = 1'b1; in_pc = 64'h20; in_instr = 32'h0010_0093; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_drop_valid", 64'(out_valid), 64'h0);
        tick();
        check("post_flush_pc", out_pc, 64'h20);
        in_valid = 1'b0;

        // Asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_pc", out_pc, 64'h0);
        check("async_rst_instr", 64'(out_instr), 64'h13);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_pc     = {$urandom, $urandom};
            in_instr  = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            reset     = $urandom_range(0, 199) == 0;
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
